// File: rtl/tone_sample_streamer.sv
// Paces an 8-bit sine oscillator at the audio sample rate, applies a click-free gate envelope to
// each captured sample and writes the widened result to both channels of the codec FIFO.
module tone_sample_streamer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned SAMPLE_HZ = 48_000,
  parameter int unsigned OUT_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    gate,
  input  logic signed [7:0]       sine,
  output logic                    osc_en,
  input  logic                    audio_out_allowed,
  output logic                    write_audio_out,
  output logic signed [OUT_W-1:0] left_channel_audio_out,
  output logic signed [OUT_W-1:0] right_channel_audio_out,
  output logic [7:0]              env,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADVANCE,
    S_LATCH,
    S_SCALE,
    S_SEND
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    osc_en_q, osc_en_d;
  logic signed [7:0]       sine_q, sine_d;
  logic [7:0]              env_q, env_d;
  logic [7:0]              drop_q, drop_d;
  logic [OUT_W-1:0]        out_q, out_d;
  logic                    tick;
  logic signed [15:0]      prod;

  // Tick counter free-runs independently of the FSM.
  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Result always fits 16 bits: [-32640, 32385].
  assign prod = 16'(sine_q) * 16'($signed({1'b0, env_q}));

  always_comb begin
    state_d         = state_q;
    osc_en_d        = 1'b0;
    sine_d          = sine_q;
    env_d           = env_q;
    drop_d          = drop_q;
    out_d           = out_q;
    write_audio_out = 1'b0;

    if (tick && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d  = S_ADVANCE;
          osc_en_d = 1'b1;
        end
      end
      S_ADVANCE: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        sine_d = sine;
        if (gate && (env_q != 8'hFF)) begin
          env_d = env_q + 8'd1;
        end else if (!gate && (env_q != 8'h00)) begin
          env_d = env_q - 8'd1;
        end
        state_d = S_SCALE;
      end
      S_SCALE: begin
        out_d                = '0;
        out_d[OUT_W-1 -: 16] = prod;
        state_d              = S_SEND;
      end
      S_SEND: begin
        write_audio_out = audio_out_allowed;
        if (audio_out_allowed) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      osc_en_q <= 1'b0;
      sine_q   <= '0;
      env_q    <= '0;
      drop_q   <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      osc_en_q <= osc_en_d;
      sine_q   <= sine_d;
      env_q    <= env_d;
      drop_q   <= drop_d;
      out_q    <= out_d;
    end
  end

  assign osc_en                  = osc_en_q;
  assign env                     = env_q;
  assign drop_cnt                = drop_q;
  assign left_channel_audio_out  = out_q;
  assign right_channel_audio_out = out_q;

endmodule

// File: tb/tb_tone_sample_streamer.sv
// Bench for tone_sample_streamer: per-cycle timing-based reference model, phase table, directed
// scaling and reset sequences.
module tb_tone_sample_streamer;

  localparam int unsigned OUT_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              gate = 1'b0;
  logic              audio_out_allowed = 1'b0;
  logic signed [7:0] sine = '0;
  logic              osc_en;
  logic              write_audio_out;
  logic [OUT_W-1:0]  left_o;
  logic [OUT_W-1:0]  right_o;
  logic [7:0]        env;
  logic [7:0]        drop_cnt;

  tone_sample_streamer #(
    .CLK_HZ   (1000),
    .SAMPLE_HZ(100),
    .OUT_W    (OUT_W)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .gate                   (gate),
    .sine                   (sine),
    .osc_en                 (osc_en),
    .audio_out_allowed      (audio_out_allowed),
    .write_audio_out        (write_audio_out),
    .left_channel_audio_out (left_o),
    .right_channel_audio_out(right_o),
    .env                    (env),
    .drop_cnt               (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending sample is described only by the cycle its tick was accepted.
  int          k;
  bit          pending;
  int          t_acc;
  int          env_m;
  int          drop_m;
  int          sine_lat;
  logic [31:0] out_m;
  int          osc_cnt;
  int          wr_cnt;
  int          first_osc;
  bit          force_en;
  int          force_sine;

  typedef struct {
    bit g;
    bit al;
    int ticks;
    int exp_env;
    int exp_drop;
    int exp_osc;
    int exp_wr;
  } phase_t;

  phase_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at model cycle %0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    pending = 1'b0;
    env_m   = 0;
    drop_m  = 0;
    out_m   = '0;
    k       = 0;
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, advances model, returns at next posedge+1.
  task automatic do_cycle(input bit g, input bit al);
    bit exp_osc, exp_wr, was_pending, tick;
    gate              = g;
    audio_out_allowed = al;
    sine              = force_en ? 8'(force_sine) : 8'($urandom);
    @(negedge clk);
    exp_osc = pending && (k == t_acc + 1);
    exp_wr  = pending && (k >= t_acc + 4) && al;
    chk("osc_en", 64'(osc_en), 64'(exp_osc));
    chk("write", 64'(write_audio_out), 64'(exp_wr));
    chk("left", 64'(left_o), 64'(out_m));
    chk("right", 64'(right_o), 64'(left_o));
    chk("env", 64'(env), 64'(env_m));
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    osc_cnt += int'(osc_en);
    wr_cnt  += int'(write_audio_out);
    if (osc_en && first_osc < 0) first_osc = k;

    was_pending = pending;
    tick        = (k % 10 == 9);
    if (pending && k == t_acc + 2) begin
      sine_lat = int'(sine);
      if (g && env_m < 255) env_m++;
      else if (!g && env_m > 0) env_m--;
    end
    if (pending && k == t_acc + 3) out_m = 32'(sine_lat * env_m) << 16;
    if (exp_wr) pending = 1'b0;
    if (tick) begin
      if (was_pending) begin
        if (drop_m < 255) drop_m++;
      end else begin
        pending = 1'b1;
        t_acc   = k;
      end
    end
    k++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_osc_en"}, 64'(osc_en), 64'(0));
    chk({tag, "_write"}, 64'(write_audio_out), 64'(0));
    chk({tag, "_left"}, 64'(left_o), 64'(0));
    chk({tag, "_right"}, 64'(right_o), 64'(0));
    chk({tag, "_env"}, 64'(env), 64'(0));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(0));
  endtask

  task automatic scale_check(input int sv, input logic [31:0] exp_out);
    force_en   = 1'b1;
    force_sine = sv;
    for (int c = 0; c < 10; c++) do_cycle(1'b1, 1'b1);
    force_en = 1'b0;
    chk("scale_left", 64'(left_o), 64'(exp_out));
    chk("scale_right", 64'(right_o), 64'(exp_out));
  endtask

  initial begin
    tbl[0] = '{g: 1'b1, al: 1'b1, ticks: 100, exp_env: 100, exp_drop: 0,   exp_osc: 100, exp_wr: 100};
    tbl[1] = '{g: 1'b1, al: 1'b1, ticks: 200, exp_env: 255, exp_drop: 0,   exp_osc: 200, exp_wr: 200};
    tbl[2] = '{g: 1'b0, al: 1'b1, ticks: 10,  exp_env: 245, exp_drop: 0,   exp_osc: 10,  exp_wr: 10};
    tbl[3] = '{g: 1'b0, al: 1'b1, ticks: 250, exp_env: 0,   exp_drop: 0,   exp_osc: 250, exp_wr: 250};
    tbl[4] = '{g: 1'b1, al: 1'b1, ticks: 3,   exp_env: 3,   exp_drop: 0,   exp_osc: 3,   exp_wr: 3};
    tbl[5] = '{g: 1'b1, al: 1'b0, ticks: 3,   exp_env: 4,   exp_drop: 2,   exp_osc: 1,   exp_wr: 0};
    tbl[6] = '{g: 1'b1, al: 1'b1, ticks: 2,   exp_env: 6,   exp_drop: 2,   exp_osc: 2,   exp_wr: 3};
    tbl[7] = '{g: 1'b1, al: 1'b0, ticks: 300, exp_env: 7,   exp_drop: 255, exp_osc: 1,   exp_wr: 0};
    tbl[8] = '{g: 1'b1, al: 1'b1, ticks: 1,   exp_env: 8,   exp_drop: 255, exp_osc: 1,   exp_wr: 2};

    force_en  = 1'b0;
    first_osc = -1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b1;

    // Offset so every phase ends with its last sample fully written.
    for (int c = 0; c < 5; c++) do_cycle(1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      osc_cnt = 0;
      wr_cnt  = 0;
      for (int c = 0; c < tbl[i].ticks * 10; c++) do_cycle(tbl[i].g, tbl[i].al);
      chk("phase_env", 64'(env), 64'(tbl[i].exp_env));
      chk("phase_drop", 64'(drop_cnt), 64'(tbl[i].exp_drop));
      chk("phase_osc_count", 64'(osc_cnt), 64'(tbl[i].exp_osc));
      chk("phase_write_count", 64'(wr_cnt), 64'(tbl[i].exp_wr));
      if (i == 1) begin
        scale_check(-128, 32'h8080_0000);
        scale_check(127, 32'h7E81_0000);
      end
      if (i == 3) chk("env0_output", 64'(left_o), 64'(0));
    end

    // Park the FSM in SEND with the FIFO full, then reset asynchronously mid-cycle.
    for (int c = 0; c < 10; c++) do_cycle(1'b1, 1'b0);
    chk("stall_left_nonzero", 64'(left_o != '0), 64'(1));
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    first_osc = -1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 30; c++) do_cycle(1'b1, 1'b1);
    chk("first_osc_after_reset", 64'(first_osc), 64'(10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
